// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient / distributed-arithmetic LUT path.
//   NTAPS     : total coefficient count
//   GRP       : taps per DA group (LUT address bits per group)
//   CW        : coefficient width (signed)
//   LW        : LUT entry width (signed), CW + log2(GRP)
//   NGRP      : number of DA groups
//   LUT_DEPTH : total LUT entries across all groups
//   coef_t    : signed coefficient
//   lut_t     : signed LUT entry
//   state_t   : loader FSM state
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int unsigned NTAPS     = 64;
   localparam int unsigned GRP       = 8;
   localparam int unsigned CW        = 16;
   localparam int unsigned LW        = 19;
   localparam int unsigned NGRP      = NTAPS / GRP;
   localparam int unsigned LUT_DEPTH = NGRP * (1 << GRP);
   localparam int unsigned CHK_W     = 32;

   typedef logic signed [CW-1:0] coef_t;
   typedef logic signed [LW-1:0] lut_t;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StEmit,
      StDone
   } state_t;

   // Sign-extend a LUT entry to the checksum accumulator width.
   function automatic logic [CHK_W-1:0] lut_sext(input lut_t v);
      return {{(CHK_W - LW){v[LW-1]}}, v};
   endfunction

endpackage

// File: rtl/da_partial_sum.sv
// -----------------------------------------------------------------------------
// da_partial_sum
// Combinational masked signed adder: sums the group coefficients whose bit is
// set in the LUT index. The result range always fits lut_t, so no saturation.
// Ports:
//   grp : GRP signed coefficients of the current group
//   n   : LUT index within the group; bit b selects grp[b]
//   sum : signed partial sum
// -----------------------------------------------------------------------------
module da_partial_sum
   import fir_pkg::*;
(
   input  coef_t            grp [GRP],
   input  logic [GRP-1:0]   n,
   output lut_t             sum
);

   always_comb begin
      sum = '0;
      for (int b = 0; b < GRP; b++) begin
         if (n[b]) begin
            sum = sum + lut_t'(grp[b]);
         end
      end
   end

endmodule

// File: rtl/da_lut_loader.sv
// -----------------------------------------------------------------------------
// da_lut_loader
// Holds the FIR coefficients and streams the distributed-arithmetic partial-sum
// table into the filter's load port, one entry per clock, then pulses done.
// Optional feature macro: DA_LUT_CHECKSUM_EN (running checksum of emitted
// entries on lut_checksum; otherwise lut_checksum is tied to 0).
// Ports:
//   clk_slow     : sole clock
//   resetn       : asynchronous active-low reset
//   coef_wr      : coefficient write strobe (ignored while a run is active)
//   coef_addr    : coefficient index
//   coef_din     : signed coefficient value
//   start        : request to generate and stream the table (accepted in idle)
//   CIN          : signed LUT entry
//   CADDR        : LUT address = group * 256 + n
//   CLOAD        : entry valid this cycle
//   busy         : generation in progress
//   done         : one-cycle pulse after the last entry
//   lut_checksum : sum of all emitted entries of the last run
// -----------------------------------------------------------------------------
module da_lut_loader
   import fir_pkg::*;
#(
   parameter int unsigned NTAPS = fir_pkg::NTAPS,
   parameter int unsigned GRP   = fir_pkg::GRP,
   parameter int unsigned CW    = fir_pkg::CW,
   parameter int unsigned LW    = fir_pkg::LW
) (
   input  logic                                   clk_slow,
   input  logic                                   resetn,
   input  logic                                   coef_wr,
   input  logic [$clog2(NTAPS)-1:0]               coef_addr,
   input  logic signed [CW-1:0]                   coef_din,
   input  logic                                   start,
   output logic signed [LW-1:0]                   CIN,
   output logic [$clog2(NTAPS/GRP)+GRP-1:0]       CADDR,
   output logic                                   CLOAD,
   output logic                                   busy,
   output logic                                   done,
   output logic [31:0]                            lut_checksum
);

   localparam int unsigned KW = $clog2(NTAPS / GRP);
   localparam int unsigned FW = $clog2(GRP);

   state_t          state;
   logic [KW-1:0]   k;
   logic [FW-1:0]   fidx;
   logic [GRP-1:0]  n;
   coef_t           coef_mem [NTAPS];
   coef_t           grp_reg  [GRP];
   lut_t            psum;

   // Coefficient store; writes only land while the FSM is idle so a running
   // table is never built from a mix of old and new coefficients.
   always_ff @(posedge clk_slow or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NTAPS; i++) begin
            coef_mem[i] <= '0;
         end
      end else if (coef_wr && (state == StIdle)) begin
         coef_mem[coef_addr] <= coef_din;
      end
   end

   da_partial_sum u_psum (
      .grp (grp_reg),
      .n   (n),
      .sum (psum)
   );

   always_ff @(posedge clk_slow or negedge resetn) begin
      if (!resetn) begin
         state <= StIdle;
         k     <= '0;
         fidx  <= '0;
         n     <= '0;
         CIN   <= '0;
         CADDR <= '0;
         CLOAD <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int i = 0; i < GRP; i++) begin
            grp_reg[i] <= '0;
         end
      end else begin
         CLOAD <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state <= StFetch;
                  k     <= '0;
                  fidx  <= '0;
               end
            end
            StFetch: begin
               busy          <= 1'b1;
               grp_reg[fidx] <= coef_mem[{k, fidx}];
               fidx          <= fidx + 1'b1;
               if (fidx == FW'(GRP - 1)) begin
                  state <= StEmit;
                  n     <= '0;
               end
            end
            StEmit: begin
               busy  <= 1'b1;
               CLOAD <= 1'b1;
               CIN   <= psum;
               CADDR <= {k, n};
               n     <= n + 1'b1;
               if (n == '1) begin
                  if (k == KW'(NTAPS / GRP - 1)) begin
                     state <= StDone;
                  end else begin
                     k     <= k + 1'b1;
                     fidx  <= '0;
                     state <= StFetch;
                  end
               end
            end
            StDone: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef DA_LUT_CHECKSUM_EN
   logic [31:0] chk_acc;

   // Cleared when a run is accepted, accumulates every emitted entry, then
   // holds its final value until the next accepted start.
   always_ff @(posedge clk_slow or negedge resetn) begin
      if (!resetn) begin
         chk_acc <= '0;
      end else if ((state == StIdle) && start) begin
         chk_acc <= '0;
      end else if (state == StEmit) begin
         chk_acc <= chk_acc + lut_sext(psum);
      end
   end

   assign lut_checksum = chk_acc;
`else
   assign lut_checksum = '0;
`endif

endmodule

// File: doc/da_lut_loader.md
# da_lut_loader

Upstream configuration stage for `fir_filter`. It holds the 64 signed 16-bit FIR coefficients and computes the 2048-entry distributed-arithmetic partial-sum table: 8 groups × 256 entries, 19-bit signed. It streams the table into the filter's `CIN`/`CADDR`/`CLOAD` load port, one entry per clock, then signals completion so the sample stream (`valid_in`) can begin.

## Interface
Parameters:
- `NTAPS`, 64, total coefficient count
- `GRP`, 8, taps per DA group (LUT address bits per group)
- `CW`, 16, coefficient width, signed
- `LW`, 19, LUT entry width, signed (CW + log2(GRP))

Ports:
- `clk_slow`  in  1  sole clock; the filter's load port is sampled on this clock
- `resetn`  in  1  asynchronous, active-low reset
- `coef_wr`  in  1  coefficient write strobe
- `coef_addr`  in  6  coefficient index 0..63
- `coef_din`  in  16  signed coefficient value
- `start`  in  1  single-cycle request to generate and stream the table
- `CIN`  out  19  signed LUT entry
- `CADDR`  out  11  LUT address = group×256 + n
- `CLOAD`  out  1  entry valid this cycle
- `busy`  out  1  generation in progress
- `done`  out  1  one-cycle pulse after the last entry
- `lut_checksum`  out  32  sum of all emitted entries (see Configuration)

## Operation
- Coefficient store: 64×16 register file, cleared to 0 on reset. `coef_wr` writes `coef_din` to `coef_addr` only while `busy`=0. Writes during `busy` are dropped.
- Entry definition: for group k (0..7) and index n (0..255), entry = Σ over b=0..7 of (bit b of n) × coef[8k+b], sign-extended to 19 bits. The range is −262144..262136, so no overflow or saturation is possible. Output is `CADDR`=256k+n, `CIN`=entry.
- FSM:
  - IDLE: `start`=1 → FETCH with k=0.
  - FETCH: copies coef[8k..8k+7] into an 8-entry group register, one per cycle, for 8 cycles → EMIT with n=0.
  - EMIT: one entry per cycle with `CLOAD`=1, n from 0 to 255. At n=255: if k<7, k+1 → FETCH; else → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored. A `start` and `coef_wr` in the same IDLE cycle: the write takes effect and `start` is accepted; group 0 fetch sees the new value.
- `CLOAD`=0 in IDLE, FETCH and DONE. `CIN`/`CADDR` hold their last values while `CLOAD`=0.
- Reset mid-operation: all state returns to IDLE immediately (asynchronous). The coefficient store is cleared and no `done` is issued.

## Timing
- Reset values: `CIN`=0, `CADDR`=0, `CLOAD`=0, `busy`=0, `done`=0, `lut_checksum`=0.
- All outputs are registered.
- Timeline relative to `start` sampled at edge t:
  - `busy`=1 from t+1.
  - Group k entries are valid on the cycles after edges t+9+264k … t+264+264k.
  - The last entry (`CADDR`=2047) follows edge t+2112.
  - `done`=1 and `busy`=0 follow edge t+2113.
- Total: 2112 busy cycles, 2048 of them with `CLOAD`=1. Each group has an 8-cycle `CLOAD` gap before it.
- A new `start` is accepted at the earliest on the cycle `done` is high (FSM is then back in IDLE on the next edge).

## Configuration
- `DA_LUT_CHECKSUM_EN` defined:
  - `lut_checksum` is a 32-bit signed accumulator of every emitted `CIN`.
  - It clears on an accepted `start`, is final when `done` pulses, and holds until the next `start`.
- Not defined: `lut_checksum` is tied to 0 and no accumulator is synthesised. The port stays present so the interface is identical in both builds.

## Structure
- Shared package `fir_pkg`: `NTAPS`, `GRP`, `CW`, `LW`, LUT depth 2048, FSM state enum (IDLE/FETCH/EMIT/DONE), and typedefs `coef_t` (signed [15:0]) and `lut_t` (signed [18:0]).
- Sub-module `da_partial_sum`: combinational 8-input masked signed adder. It takes the 8-entry group register and n[7:0] and returns `lut_t`. The top instantiates one.

## Test plan
- Reset: hold `resetn`=0 → all outputs 0. Release, then `start` with all coefficients 0 → 2048 `CLOAD` cycles, all `CIN`=0, `done` one cycle after edge t+2113.
- All coefficients 1 → `CIN` = popcount(n) per entry: `CADDR` 0→0, 255→8, 256→0, 2047→8. With macro defined, `lut_checksum`=8192.
- All coefficients −32768 → `CADDR` 255 gives `CIN`=−262144 (19'h40000) and `CADDR` 1 gives −32768. Checks the sign-extension boundary.
- coef[8]=100, coef[15]=−7, others 0 → `CADDR` 385 (n=129) = 93, `CADDR` 257 = 100, `CADDR` 0..255 all 0.
- During a run: pulse `start`, and write coef[0]=5 → no restart, `done` still at t+2113, table reflects the old coef[0]. A second run then gives `CADDR` 1 = 5.
- Assert `resetn`=0 when `CADDR`=1000 → `CLOAD`/`busy` 0 immediately, no `done`. A fresh `start` streams from `CADDR` 0 with all-zero coefficients.
